// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder in front of a word-addressed SRAM, with a programmable
// number of data-phase wait states and a two-cycle ERROR response for illegal transfers.
module ahb_sram_slave #(
  parameter int WORD_SIZE   = 32,
  parameter int ADDR_LENGTH = 32,
  parameter int MEM_BYTES   = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hsel,
  input  logic [ADDR_LENGTH-1:0] haddr,
  input  logic [1:0]             htrans,
  input  logic                   hwrite,
  input  logic [2:0]             hsize,
  input  logic [2:0]             hburst,
  input  logic [3:0]             hprot,
  input  logic [WORD_SIZE-1:0]   hwdata,
  input  logic                   hready,
  output logic                   hreadyout,
  output logic [WORD_SIZE-1:0]   hrdata,
  output logic                   hresp
);

  localparam int         AW    = $clog2(MEM_BYTES);
  localparam int         WORDS = MEM_BYTES / 4;
  localparam logic [2:0] WS    = 3'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, ACCESS, ERR1, ERR2} state_t;

  state_t                 state, state_nxt;
  logic [2:0]             wcnt, wcnt_nxt;
  logic [ADDR_LENGTH-1:0] addr_r;
  logic                   write_r;
  logic [2:0]             size_r;
  logic [WORD_SIZE-1:0]   mem [WORDS];

  logic                   accept, illegal, complete, misaligned, out_of_range;
  logic [3:0]             be;
  logic [AW-3:0]          widx;

  always_comb begin
    hreadyout    = 1'b1;
    hresp        = 1'b0;
    state_nxt    = state;
    wcnt_nxt     = wcnt;
    misaligned   = (hsize == 3'd1 && haddr[0]) || (hsize == 3'd2 && haddr[1:0] != 2'b00);
    out_of_range = |haddr[ADDR_LENGTH-1:AW];
    illegal      = (hsize > 3'd2) || misaligned || out_of_range;

    case (state)
      ACCESS:  hreadyout = (wcnt == WS);
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      ERR2:    hresp = 1'b1;
      default: ;
    endcase

    // Gating on our own hreadyout keeps ERR1 and wait cycles from accepting
    // even if hready is sourced from elsewhere.
    accept   = hsel && htrans[1] && hready && hreadyout;
    complete = (state == ACCESS) && hreadyout;

    case (state)
      ERR1: state_nxt = ERR2;
      default: begin
        if (state == ACCESS && !hreadyout) begin
          wcnt_nxt = wcnt + 3'd1;
        end else if (accept) begin
          state_nxt = illegal ? ERR1 : ACCESS;
          wcnt_nxt  = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wcnt    <= '0;
      addr_r  <= '0;
      write_r <= 1'b0;
      size_r  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (accept) begin
        addr_r  <= haddr;
        write_r <= hwrite;
        size_r  <= hsize;
      end
    end
  end

  assign widx = addr_r[AW-1:2];

  always_comb begin
    case (size_r)
      3'd0:    be = 4'b0001 << addr_r[1:0];
      3'd1:    be = addr_r[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Memory is deliberately left out of reset; an async reset forces state to
  // IDLE, so a write still in its wait states never reaches this block.
  always_ff @(posedge clk) begin
    if (complete && write_r) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    hrdata = '0;
    if (complete && !write_r) hrdata = mem[widx];
  end

  logic unused_ok;
  assign unused_ok = ^{hburst, hprot, addr_r[ADDR_LENGTH-1:AW]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: three instances (0, 2 and 3 wait states)
// checked every cycle against a transaction-level byte-memory model.
module tb_ahb_sram_slave;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [2:0]  hsel_v = '0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = '0;
  logic [2:0]  hburst = '0;
  logic [3:0]  hprot = '0;
  logic [31:0] hwdata = '0;
  logic        hr_block = 1'b0;

  logic        hro0, hro1, hro2, hrs0, hrs1, hrs2, hrdy0, hrdy1, hrdy2;
  logic [31:0] hrd0, hrd1, hrd2;

  assign hrdy0 = hro0 & ~hr_block;
  assign hrdy1 = hro1;
  assign hrdy2 = hro2;

  always #5 clk = ~clk;

  ahb_sram_slave #(.WORD_SIZE(32), .ADDR_LENGTH(32), .MEM_BYTES(4096), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .hsel(hsel_v[0]), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata), .hready(hrdy0),
    .hreadyout(hro0), .hrdata(hrd0), .hresp(hrs0));
  ahb_sram_slave #(.WORD_SIZE(32), .ADDR_LENGTH(32), .MEM_BYTES(4096), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst_n(rst_n), .hsel(hsel_v[1]), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata), .hready(hrdy1),
    .hreadyout(hro1), .hrdata(hrd1), .hresp(hrs1));
  ahb_sram_slave #(.WORD_SIZE(32), .ADDR_LENGTH(32), .MEM_BYTES(4096), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n), .hsel(hsel_v[2]), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata), .hready(hrdy2),
    .hreadyout(hro2), .hrdata(hrd2), .hresp(hrs2));

  int unsigned checks = 0, passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic rdy_of(input int d);
    return (d == 0) ? hro0 : (d == 1) ? hro1 : hro2;
  endfunction
  function automatic logic resp_of(input int d);
    return (d == 0) ? hrs0 : (d == 1) ? hrs1 : hrs2;
  endfunction
  function automatic logic [31:0] rdata_of(input int d);
    return (d == 0) ? hrd0 : (d == 1) ? hrd1 : hrd2;
  endfunction

  // Model: each accepted transfer expands into its per-cycle response list.
  typedef struct {
    bit          rdy;
    bit          resp;
    bit          chk;
    logic [31:0] data;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
  } item_t;

  item_t       pend [3][10];
  int unsigned cnt  [3];
  logic [7:0]  mb   [3][4096];
  bit          kb   [3][4096];
  int unsigned ws   [3] = '{0, 2, 3};

  function automatic item_t idle_item();
    item_t it;
    it = '{default: 0};
    it.rdy = 1'b1;
    it.chk = 1'b1;
    return it;
  endfunction

  task automatic push(input int d, input item_t it);
    pend[d][cnt[d]] = it;
    cnt[d]++;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) cnt[d] = 0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        item_t       cur, it;
        bit          erdy, bad;
        int unsigned base;
        cur  = (cnt[d] != 0) ? pend[d][0] : idle_item();
        erdy = cur.rdy && !(d == 0 && hr_block);
        if (cnt[d] != 0 && cur.rdy && cur.wr) begin
          for (int unsigned k = 0; k < (32'd1 << cur.size); k++) begin
            mb[d][cur.addr + k] = hwdata[8*((cur.addr % 4) + k) +: 8];
            kb[d][cur.addr + k] = 1'b1;
          end
        end
        if (cnt[d] != 0) begin
          for (int i = 0; i < 9; i++) pend[d][i] = pend[d][i+1];
          cnt[d]--;
        end
        if (hsel_v[d] && htrans[1] && erdy) begin
          bad = (hsize > 3'd2) || (haddr % (32'd1 << hsize) != 0) || (haddr >= 32'd4096);
          if (bad) begin
            it = idle_item(); it.rdy = 1'b0; it.resp = 1'b1; push(d, it);
            it.rdy = 1'b1; push(d, it);
          end else begin
            it = idle_item(); it.rdy = 1'b0;
            for (int unsigned i = 0; i < ws[d]; i++) push(d, it);
            it = idle_item(); it.wr = hwrite; it.addr = haddr; it.size = hsize;
            if (!hwrite) begin
              base    = haddr - (haddr % 4);
              it.chk  = kb[d][base] && kb[d][base+1] && kb[d][base+2] && kb[d][base+3];
              it.data = {mb[d][base+3], mb[d][base+2], mb[d][base+1], mb[d][base]};
            end
            push(d, it);
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      item_t e;
      e = (cnt[d] != 0) ? pend[d][0] : idle_item();
      checks++;
      if (rdy_of(d) === e.rdy && resp_of(d) === e.resp && (!e.chk || rdata_of(d) === e.data))
        passes++;
      else
        $display("FAIL cycle dut%0d t=%0t: ready/resp/rdata got %b/%b/%h want %b/%b/%h",
                 d, $time, rdy_of(d), resp_of(d), rdata_of(d), e.rdy, e.resp, e.data);
    end
  end

  // Master side: one address phase; observes the previous transfer's data phase.
  logic [31:0] prev_wd = '0, last_rdata;
  logic        first_resp, last_resp;
  int unsigned nwait;

  task automatic beat(input int d, input logic [1:0] tr, input logic [31:0] a, input logic w,
                      input logic [2:0] sz, input logic [31:0] wd, input logic sel);
    bit done, first, r;
    hsel_v = sel ? (3'b001 << d) : 3'b000;
    htrans = tr; haddr = a; hwrite = w; hsize = sz; hwdata = prev_wd;
    nwait = 0; first = 1'b1; done = 1'b0;
    for (int unsigned c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      r = rdy_of(d);
      if (first) begin first_resp = resp_of(d); first = 1'b0; end
      if (r) begin last_resp = resp_of(d); last_rdata = rdata_of(d); end
      else nwait++;
      @(posedge clk); #1;
      done = r;
    end
    if (!done) check("ready_timeout", 32'd0, 32'd1);
    prev_wd = wd;
  endtask

  task automatic idle_beat(input int d, input logic [31:0] wd);
    beat(d, T_IDLE, 32'h0, 1'b0, 3'd0, wd, 1'b1);
  endtask

  initial begin
    #3;
    check("reset_ready", {29'd0, hro2, hro1, hro0}, 32'h7);
    check("reset_resp",  {29'd0, hrs2, hrs1, hrs0}, 32'h0);
    check("reset_rdata", hrd0 | hrd1 | hrd2, 32'h0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;

    // zero-wait write then pipelined read
    beat(0, T_NS, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 1'b1);
    beat(0, T_NS, 32'h10, 1'b0, 3'd2, 32'h0, 1'b1);
    check("ws0_write_wait", nwait, 0);
    idle_beat(0, 32'h0);
    check("ws0_read_wait", nwait, 0);
    check("ws0_read_data", last_rdata, 32'hDEADBEEF);

    // two wait states
    beat(1, T_NS, 32'h20, 1'b1, 3'd2, 32'h5A5A1234, 1'b1);
    beat(1, T_NS, 32'h20, 1'b0, 3'd2, 32'h0, 1'b1);
    check("ws2_write_wait", nwait, 2);
    idle_beat(1, 32'h0);
    check("ws2_read_wait", nwait, 2);
    check("ws2_read_data", last_rdata, 32'h5A5A1234);

    // byte / halfword merge
    beat(0, T_NS, 32'h30, 1'b1, 3'd2, 32'h11223344, 1'b1);
    beat(0, T_NS, 32'h31, 1'b1, 3'd0, 32'h0000AA00, 1'b1);
    beat(0, T_NS, 32'h32, 1'b1, 3'd1, 32'hBBCC0000, 1'b1);
    beat(0, T_NS, 32'h30, 1'b0, 3'd2, 32'h0, 1'b1);
    idle_beat(0, 32'h0);
    check("merge_data", last_rdata, 32'hBBCCAA44);

    // error responses
    beat(0, T_NS, 32'h0, 1'b1, 3'd2, 32'h76543210, 1'b1);
    idle_beat(0, 32'h0);
    beat(0, T_NS, 32'h1002, 1'b0, 3'd2, 32'h0, 1'b1);
    idle_beat(0, 32'h0);
    check("err_misaligned_waits", nwait, 1);
    check("err_misaligned_resp", {30'd0, first_resp, last_resp}, 32'h3);
    beat(0, T_NS, 32'h1000, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b1);
    idle_beat(0, 32'h0);
    check("err_range_waits", nwait, 1);
    check("err_range_resp", {30'd0, first_resp, last_resp}, 32'h3);
    beat(0, T_NS, 32'h8, 1'b0, 3'd3, 32'h0, 1'b1);
    idle_beat(0, 32'h0);
    check("err_size_resp", {30'd0, first_resp, last_resp}, 32'h3);
    beat(0, T_NS, 32'h0, 1'b0, 3'd2, 32'h0, 1'b1);
    idle_beat(0, 32'h0);
    check("err_word0_kept", last_rdata, 32'h76543210);

    // IDLE/BUSY/deselected/hready-low cycles between NONSEQs
    beat(0, T_NS,   32'h54, 1'b1, 3'd2, 32'h0BADF00D, 1'b1);
    beat(0, T_BUSY, 32'h54, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b1);
    beat(0, T_IDLE, 32'h54, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b1);
    check("busy_zero_wait", {nwait[30:0], last_resp}, 32'h0);
    beat(0, T_NS,   32'h54, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b0);
    hr_block = 1'b1;
    beat(0, T_NS,   32'h54, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b1);
    hr_block = 1'b0;
    beat(0, T_NS,   32'h54, 1'b0, 3'd2, 32'h0, 1'b1);
    check("blocked_zero_wait", nwait, 0);
    beat(0, T_BUSY, 32'h58, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b1);
    check("nontransfer_read_data", last_rdata, 32'h0BADF00D);
    idle_beat(0, 32'hFFFFFFFF);

    // reset during the second wait cycle of a write
    beat(2, T_NS, 32'h40, 1'b1, 3'd2, 32'h01020304, 1'b1);
    idle_beat(2, 32'h0);
    hsel_v = 3'b100; htrans = T_NS; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2; hwdata = prev_wd;
    @(posedge clk); #1;
    htrans = T_IDLE; hwdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    check("rstmid_pre_ready", {31'd0, hro2}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_async", {hro2, hrs2, 30'd0} | hrd2, 32'h80000000);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    prev_wd = '0;
    beat(2, T_NS, 32'h40, 1'b0, 3'd2, 32'h0, 1'b1);
    idle_beat(2, 32'h0);
    check("rstmid_wait", nwait, 3);
    check("rstmid_kept", last_rdata, 32'h01020304);

    hsel_v = '0;
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
